uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_if.sv | 23 ++
 rtl/baud_tick_gen.sv | 33 +++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receiver state encoding and vote helper
// Contents: OVERSAMPLE ticks per bit, mid-bit sample positions, data width,
//           uart_state_e receiver states, maj3() 2-of-3 vote.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_LO     = 7;
  localparam int MID        = 8;
  localparam int MID_HI     = 9;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte handshake bundle between uart_rx and its consumer
// Signals: data[7:0] received byte, valid byte available, ready consumer accept,
//          frame_err bad stop bit pulse, overrun dropped byte pulse.
// master = receiver side, slave = consumer side.
interface uart_rx_if;

  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output data, valid, frame_err, overrun,
    input  ready
  );

  modport slave (
    input  data, valid, frame_err, overrun,
    output ready
  );

endinterface

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - oversample tick divider, phase-resettable
// Ports: clk, rst_n (async active-low), clear (restart the phase at 0),
//        tick (one-cycle pulse every DIV clocks).
module baud_tick_gen #(
  parameter int CLK_HZ     = 48_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  // Clocks per oversample tick, rounded to nearest.
  localparam int DIV = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int CW  = ($clog2(DIV) > 0) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, 16x oversampling with mid-bit 2-of-3 vote
// Ports: clk, rst_n (async active-low), rxd (async serial in, idles high),
//        rx (uart_rx_if.master: data/valid/ready handshake, frame_err, overrun pulses).
module uart_rx #(
  parameter int CLK_HZ     = 48_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rxd,
  uart_rx_if.master    rx
);

  import uart_pkg::*;

  uart_state_e state, state_nx;

  logic       sync1, rxd_s, rxd_prev;
  logic       fall, clear, tick;
  logic [3:0] scnt;
  logic [2:0] bit_idx;
  logic       s_lo, s_mid, maj;
  logic       at_mid, at_end;
  logic [7:0] shift;
  logic       stop_good, stop_bad, good_pend;
  logic [7:0] data_q;
  logic       valid_q, frame_err_q, overrun_q;

  baud_tick_gen #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .tick  (tick)
  );

  // Synchronizer and previous-sample flops idle high so reset never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      sync1    <= rxd;
      rxd_s    <= sync1;
      rxd_prev <= rxd_s;
    end
  end

  assign fall   = rxd_prev & ~rxd_s;
  assign clear  = (state == IDLE) && fall;
  assign at_mid = tick && (scnt == 4'(MID_HI));
  assign at_end = tick && (scnt == 4'(OVERSAMPLE - 1));
  // Third vote is the live sample taken at the decision tick itself.
  assign maj    = maj3(s_lo, s_mid, rxd_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE:  if (fall) state_nx = START;
      START: begin
        if (at_mid && maj)  state_nx = IDLE;   // glitch, not a start bit
        else if (at_end)    state_nx = DATA;
      end
      DATA:  if (at_end && (bit_idx == 3'(DATA_BITS - 1))) state_nx = STOP;
      STOP: begin
        // Leave mid stop bit so a back-to-back start edge is never missed.
        if (at_mid) begin
          if (maj) begin
            stop_good = 1'b1;
            state_nx  = IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nx  = BREAK;
          end
        end
      end
      BREAK: if (rxd_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt    <= '0;
      bit_idx <= '0;
      s_lo    <= 1'b1;
      s_mid   <= 1'b1;
      shift   <= '0;
    end else begin
      if (clear)     scnt <= '0;
      else if (tick) scnt <= scnt + 1'b1;
      if (tick && (scnt == 4'(MID_LO))) s_lo  <= rxd_s;
      if (tick && (scnt == 4'(MID)))    s_mid <= rxd_s;
      if ((state == START) && at_end) bit_idx <= '0;
      if ((state == DATA) && at_mid)  shift   <= {maj, shift[7:1]};   // LSB first
      if ((state == DATA) && at_end)  bit_idx <= bit_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_pend   <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      good_pend   <= stop_good;
      frame_err_q <= stop_bad;
      overrun_q   <= 1'b0;
      if (good_pend) begin
        // A byte accepted this cycle frees the slot for the new one.
        if (!valid_q || rx.ready) begin
          data_q  <= shift;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && rx.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx.data      = data_q;
  assign rx.valid     = valid_q;
  assign rx.frame_err = frame_err_q;
  assign rx.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a line-level sender and byte scoreboard
module tb_uart_rx;

  localparam int P_NOM  = 416667;   // sender bit period in milli-clocks at 115200
  localparam int P_FAST = 406504;   // +2.5% baud
  localparam int P_SLOW = 427350;   // -2.5% baud

  logic clk = 1'b0;
  logic rst_n;
  logic rxd;

  uart_rx_if bus ();

  uart_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rxd   (rxd),
    .rx    (bus)
  );

  always #10 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int both_cnt = 0;
  logic valid_d = 1'b0;
  logic [7:0] got_q[$];

  always @(posedge clk) cyc++;

  // Inputs change just after posedge, so at negedge valid&ready is exactly
  // what the next edge acts on.
  always @(negedge clk) begin
    if (bus.valid && bus.ready) got_q.push_back(bus.data);
    if (bus.frame_err) ferr_cnt++;
    if (bus.overrun) ovr_cnt++;
    if (bus.frame_err && bus.overrun) both_cnt++;
    if (bus.valid && !valid_d) rise_cyc = cyc;
    valid_d = bus.valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int p_x1000);
    logic [9:0] bits;
    int t;
    int n_end;
    bits = {stop_bit, b, 1'b0};
    t = 0;
    for (int k = 0; k < 10; k++) begin
      rxd = bits[k];
      if (k == 0) fall_cyc = cyc;
      n_end = ((k + 1) * p_x1000 + 500) / 1000;
      step(n_end - t);
      t = n_end;
    end
  endtask

  // Compare bytes accepted since base against the expected list.
  task automatic chk_bytes(input string tag, input int base, input logic [7:0] exp_q[$]);
    int n;
    n = got_q.size() - base;
    chk({tag, "_count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      chk({tag, "_byte"}, got_q[base + i], exp_q[i]);
  endtask

  initial begin
    int gb, fb, ob, lat;
    logic [7:0] exp_q[$];
    logic [7:0] rb;
    logic rs;

    rst_n = 1'b0;
    rxd = 1'b1;
    bus.ready = 1'b1;
    step(5);
    chk("rst_data", bus.data, 8'h00);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_frame_err", bus.frame_err, 1'b0);
    chk("rst_overrun", bus.overrun, 1'b0);
    rst_n = 1'b1;
    step(20);

    // 1: single byte, latency from falling edge to valid
    gb = got_q.size(); fb = ferr_cnt; ob = ovr_cnt;
    send_frame(8'h55, 1'b1, P_NOM);
    step(20);
    exp_q = '{8'h55};
    chk_bytes("t1", gb, exp_q);
    chk("t1_frame_err", ferr_cnt - fb, 0);
    chk("t1_overrun", ovr_cnt - ob, 0);
    lat = rise_cyc - fall_cyc;
    n_assert++;
    assert (lat >= 4000 && lat <= 4015) else begin
      n_fail++;
      $error("FAIL t1_latency: observed %0d expected 4000..4015", lat);
    end

    // 2: short low glitch is rejected, next frame still received
    gb = got_q.size();
    rxd = 1'b0; step(100);
    rxd = 1'b1; step(400);
    chk("t2_glitch_bytes", got_q.size() - gb, 0);
    chk("t2_glitch_valid", bus.valid, 1'b0);
    send_frame(8'hA3, 1'b1, P_NOM);
    step(20);
    exp_q = '{8'hA3};
    chk_bytes("t2", gb, exp_q);

    // 3: bad stop bit followed by a held-low line
    gb = got_q.size(); fb = ferr_cnt;
    send_frame(8'hA5, 1'b0, P_NOM);
    rxd = 1'b0; step(5000);
    rxd = 1'b1; step(100);
    chk("t3_frame_err_pulses", ferr_cnt - fb, 1);
    chk("t3_bytes", got_q.size() - gb, 0);
    chk("t3_valid", bus.valid, 1'b0);
    send_frame(8'h3C, 1'b1, P_NOM);
    step(20);
    chk("t3_valid_after", bus.valid | (got_q.size() > gb), 1'b1);
    exp_q = '{8'h3C};
    chk_bytes("t3", gb, exp_q);

    // 4: overrun while the first byte is held
    gb = got_q.size(); ob = ovr_cnt;
    bus.ready = 1'b0;
    send_frame(8'h11, 1'b1, P_NOM);
    chk("t4_valid_first", bus.valid, 1'b1);
    chk("t4_data_first", bus.data, 8'h11);
    send_frame(8'h22, 1'b1, P_NOM);
    step(20);
    chk("t4_overrun_pulses", ovr_cnt - ob, 1);
    chk("t4_valid_held", bus.valid, 1'b1);
    chk("t4_data_held", bus.data, 8'h11);
    chk("t4_no_accept", got_q.size() - gb, 0);
    bus.ready = 1'b1;
    step(1);
    bus.ready = 1'b0;
    chk("t4_valid_cleared", bus.valid, 1'b0);
    exp_q = '{8'h11};
    chk_bytes("t4", gb, exp_q);
    bus.ready = 1'b1;
    step(5);

    // 5: back-to-back frames with sender baud off by +/-2.5%
    gb = got_q.size(); fb = ferr_cnt;
    send_frame(8'hFF, 1'b1, P_FAST);
    send_frame(8'h00, 1'b1, P_FAST);
    send_frame(8'h80, 1'b1, P_FAST);
    step(20);
    exp_q = '{8'hFF, 8'h00, 8'h80};
    chk_bytes("t5_fast", gb, exp_q);
    gb = got_q.size();
    send_frame(8'hFF, 1'b1, P_SLOW);
    send_frame(8'h00, 1'b1, P_SLOW);
    send_frame(8'h80, 1'b1, P_SLOW);
    step(20);
    chk_bytes("t5_slow", gb, exp_q);
    chk("t5_frame_err", ferr_cnt - fb, 0);

    // random frames: a good stop delivers the byte, a bad one only flags frame_err
    gb = got_q.size(); fb = ferr_cnt;
    exp_q = {};
    lat = 0;
    for (int i = 0; i < 3; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs, P_NOM);
      if (rs) exp_q.push_back(rb);
      else lat++;
      rxd = 1'b1;
      step(rs ? $urandom_range(0, 100) : 500 + $urandom_range(0, 100));
    end
    step(20);
    chk_bytes("rnd", gb, exp_q);
    chk("rnd_frame_err", ferr_cnt - fb, lat);

    // 6: reset during bit 4 of 0x7E; the sender abandons that frame
    gb = got_q.size();
    rxd = 1'b0; step(417);
    for (int k = 0; k < 4; k++) begin
      rb = 8'h7E;
      rxd = rb[k];
      step(417);
    end
    rb = 8'h7E;
    rxd = rb[4];
    step(200);
    rst_n = 1'b0;
    step(1);
    chk("t6_rst_data", bus.data, 8'h00);
    chk("t6_rst_valid", bus.valid, 1'b0);
    chk("t6_rst_frame_err", bus.frame_err, 1'b0);
    chk("t6_rst_overrun", bus.overrun, 1'b0);
    step(9);
    rst_n = 1'b1;
    rxd = 1'b1;
    step(1500);
    chk("t6_no_bytes", got_q.size() - gb, 0);
    chk("t6_valid_idle", bus.valid, 1'b0);
    chk("t6_data_idle", bus.data, 8'h00);
    send_frame(8'h7E, 1'b1, P_NOM);
    step(20);
    exp_q = '{8'h7E};
    chk_bytes("t6", gb, exp_q);

    chk("err_ovr_same_cycle", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
